// File: rtl/force_step_sequencer_if.sv
`default_nettype none
// ==== force_step_sequencer_if (rev 1.0) ====
// Step request, generator launch/stream inputs and summed force outputs of force_step_sequencer.
interface force_step_sequencer_if #(
  parameter int NUM_NODES  = 10,
  parameter int NUM_GENS   = 3,
  parameter int FORCE_SIZE = 8,
  parameter int ACC_SIZE   = 12
);
  logic                         step_in;
  logic [NUM_GENS-1:0]          gen_begin_out;
  logic signed [FORCE_SIZE-1:0] gen_force_x_in [NUM_GENS];
  logic signed [FORCE_SIZE-1:0] gen_force_y_in [NUM_GENS];
  logic [NUM_GENS-1:0]          gen_valid_in;
  logic [NUM_GENS-1:0]          gen_done_in;
  logic signed [ACC_SIZE-1:0]   force_x_out [NUM_NODES];
  logic signed [ACC_SIZE-1:0]   force_y_out [NUM_NODES];
  logic                         busy_out;
  logic                         step_done_out;
  logic                         timeout_err_out;
  logic                         beat_err_out;

  modport master (
    output step_in, gen_force_x_in, gen_force_y_in, gen_valid_in, gen_done_in,
    input  gen_begin_out, force_x_out, force_y_out, busy_out, step_done_out,
           timeout_err_out, beat_err_out
  );

  modport slave (
    input  step_in, gen_force_x_in, gen_force_y_in, gen_valid_in, gen_done_in,
    output gen_begin_out, force_x_out, force_y_out, busy_out, step_done_out,
           timeout_err_out, beat_err_out
  );
endinterface
`default_nettype wire

// File: rtl/force_step_sequencer.sv
`default_nettype none
// ==== force_step_sequencer (rev 1.0) ====
// Launches force generators in turn and sums their per-node streams into saturating X/Y accumulators.
module force_step_sequencer #(
  parameter int NUM_NODES  = 10,
  parameter int NUM_GENS   = 3,
  parameter int FORCE_SIZE = 8,
  parameter int ACC_SIZE   = 12,
  parameter int TIMEOUT    = 64
) (
  input  wire logic             clk_in,
  input  wire logic             rst_in,
  force_step_sequencer_if.slave bus
);
  localparam int GEN_W  = (NUM_GENS > 1) ? $clog2(NUM_GENS) : 1;
  localparam int BEAT_W = $clog2(NUM_NODES + 1);
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GEN_W-1:0]    LAST_GEN = GEN_W'(NUM_GENS - 1);
  localparam logic [BEAT_W-1:0]   BEAT_MAX = BEAT_W'(NUM_NODES);
  localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [NUM_GENS-1:0] GEN_ONE  = NUM_GENS'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LAUNCH  = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                     state;
  logic [GEN_W-1:0]           gen_idx;
  logic [BEAT_W-1:0]          beat;
  logic [WD_W-1:0]            wdog;
  logic [NUM_GENS-1:0]        begin_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       timeout_err_q;
  logic                       beat_err_q;
  logic signed [ACC_SIZE-1:0] acc_x [NUM_NODES];
  logic signed [ACC_SIZE-1:0] acc_y [NUM_NODES];

  logic                         sel_valid;
  logic                         sel_done;
  logic                         advance;
  logic signed [FORCE_SIZE-1:0] sel_fx;
  logic signed [FORCE_SIZE-1:0] sel_fy;

  assign sel_valid = bus.gen_valid_in[gen_idx];
  assign sel_done  = bus.gen_done_in[gen_idx];
  assign sel_fx    = bus.gen_force_x_in[gen_idx];
  assign sel_fy    = bus.gen_force_y_in[gen_idx];
  // A watchdog expiry moves on exactly like a done pulse would.
  assign advance   = sel_done || (wdog == WD_LAST);

  function automatic logic signed [ACC_SIZE-1:0] sat_add(
    input logic signed [ACC_SIZE-1:0]   acc,
    input logic signed [FORCE_SIZE-1:0] f
  );
    logic signed [ACC_SIZE:0] sum;
    sum = {acc[ACC_SIZE-1], acc} + {{(ACC_SIZE + 1 - FORCE_SIZE){f[FORCE_SIZE-1]}}, f};
    if (sum[ACC_SIZE] != sum[ACC_SIZE-1])
      sat_add = sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    else
      sat_add = sum[ACC_SIZE-1:0];
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      gen_idx       <= '0;
      beat          <= '0;
      wdog          <= '0;
      begin_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      beat_err_q    <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        acc_x[n] <= '0;
        acc_y[n] <= '0;
      end
    end else begin
      begin_q <= '0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.step_in) begin
            busy_q <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          for (int n = 0; n < NUM_NODES; n++) begin
            acc_x[n] <= '0;
            acc_y[n] <= '0;
          end
          timeout_err_q <= 1'b0;
          beat_err_q    <= 1'b0;
          gen_idx       <= '0;
          begin_q       <= GEN_ONE;
          state         <= LAUNCH;
        end
        LAUNCH: begin
          beat  <= '0;
          wdog  <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          if (sel_valid) begin
            if (beat < BEAT_MAX) begin
              acc_x[beat] <= sat_add(acc_x[beat], sel_fx);
              acc_y[beat] <= sat_add(acc_y[beat], sel_fy);
              beat        <= beat + 1'b1;
            end else begin
              beat_err_q <= 1'b1;
            end
          end
          if (advance) begin
            if (!sel_done)
              timeout_err_q <= 1'b1;
            if (gen_idx == LAST_GEN) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              gen_idx <= gen_idx + 1'b1;
              begin_q <= GEN_ONE << (gen_idx + 1'b1);
              state   <= LAUNCH;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gen_begin_out   = begin_q;
  assign bus.busy_out        = busy_q;
  assign bus.step_done_out   = done_q;
  assign bus.timeout_err_out = timeout_err_q;
  assign bus.beat_err_out    = beat_err_q;

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_force_out
    assign bus.force_x_out[n] = acc_x[n];
    assign bus.force_y_out[n] = acc_y[n];
  end
endmodule
`default_nettype wire

// File: tb/tb_force_step_sequencer.sv
`default_nettype none
// ==== tb_force_step_sequencer (rev 1.0) ====
// Random generator streams against a per-node saturating-sum model, on a 12-bit and an 8-bit instance.
module tb_force_step_sequencer;
  localparam int NN = 10, NG = 3, FS = 8, AW = 12, AN = 8, TO = 64, MAXB = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 step = 1'b0;
  logic [NG-1:0]        gv = '0;
  logic [NG-1:0]        gd = '0;
  logic signed [FS-1:0] gfx [NG];
  logic signed [FS-1:0] gfy [NG];

  force_step_sequencer_if #(.NUM_NODES(NN), .NUM_GENS(NG), .FORCE_SIZE(FS), .ACC_SIZE(AW)) bw ();
  force_step_sequencer_if #(.NUM_NODES(NN), .NUM_GENS(NG), .FORCE_SIZE(FS), .ACC_SIZE(AN)) bn ();

  assign bw.step_in = step;          assign bn.step_in = step;
  assign bw.gen_valid_in = gv;       assign bn.gen_valid_in = gv;
  assign bw.gen_done_in = gd;        assign bn.gen_done_in = gd;
  assign bw.gen_force_x_in = gfx;    assign bn.gen_force_x_in = gfx;
  assign bw.gen_force_y_in = gfy;    assign bn.gen_force_y_in = gfy;

  force_step_sequencer #(.NUM_NODES(NN), .NUM_GENS(NG), .FORCE_SIZE(FS), .ACC_SIZE(AW), .TIMEOUT(TO))
    dut_w (.clk_in(clk), .rst_in(rst), .bus(bw.slave));
  force_step_sequencer #(.NUM_NODES(NN), .NUM_GENS(NG), .FORCE_SIZE(FS), .ACC_SIZE(AN), .TIMEOUT(TO))
    dut_n (.clk_in(clk), .rst_in(rst), .bus(bn.slave));

  int checks = 0, errors = 0;
  int mxw[NN], myw[NN], mxn[NN], myn[NN];
  int exp_to, exp_be, beat_cnt, cyc, gmax;
  int nb[NG], mode[NG];          // mode 0: done with last beat, 1: done afterwards, 2: hung
  int px[NG][MAXB], py[NG][MAXB];
  bit step_noise = 1'b0;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Everything except the active generator is random noise; g < 0 means none is active.
  task automatic drive_cycle(input int g, input bit v, input bit d, input int fx, input int fy);
    for (int h = 0; h < NG; h++) begin
      gv[h]  = 1'($urandom);
      gd[h]  = 1'($urandom);
      gfx[h] = FS'($urandom);
      gfy[h] = FS'($urandom);
    end
    if (g >= 0) begin
      gv[g] = v;
      gd[g] = d;
      if (v) begin
        gfx[g] = FS'(fx);
        gfy[g] = FS'(fy);
      end
    end
    step = step_noise && ($urandom_range(0, 7) == 0);
  endtask

  task automatic collect_cycle(input int g, input bit v, input bit d, input int fx, input int fy);
    @(negedge clk);
    if (cyc == 0) check_value("begin_width", int'(bw.gen_begin_out), 0);
    drive_cycle(g, v, d, fx, fy);
    cyc++;
  endtask

  task automatic model_beat(input int g, input int k);
    if (beat_cnt < NN) begin
      mxw[beat_cnt] = clip(mxw[beat_cnt] + px[g][k], AW);
      myw[beat_cnt] = clip(myw[beat_cnt] + py[g][k], AW);
      mxn[beat_cnt] = clip(mxn[beat_cnt] + px[g][k], AN);
      myn[beat_cnt] = clip(myn[beat_cnt] + py[g][k], AN);
      beat_cnt++;
    end else begin
      exp_be = 1;
    end
  endtask

  task automatic check_forces(input string tag);
    for (int n = 0; n < NN; n++) begin
      check_value($sformatf("%s fx12[%0d]", tag, n), int'(bw.force_x_out[n]), mxw[n]);
      check_value($sformatf("%s fy12[%0d]", tag, n), int'(bw.force_y_out[n]), myw[n]);
      check_value($sformatf("%s fx8[%0d]", tag, n), int'(bn.force_x_out[n]), mxn[n]);
      check_value($sformatf("%s fy8[%0d]", tag, n), int'(bn.force_y_out[n]), myn[n]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int n = 0; n < NN; n++) begin
      mxw[n] = 0; myw[n] = 0; mxn[n] = 0; myn[n] = 0;
    end
    check_value({tag, " begin"}, int'(bw.gen_begin_out) | int'(bn.gen_begin_out), 0);
    check_value({tag, " busy"}, int'(bw.busy_out) | int'(bn.busy_out), 0);
    check_value({tag, " step_done"}, int'(bw.step_done_out) | int'(bn.step_done_out), 0);
    check_value({tag, " timeout_err"}, int'(bw.timeout_err_out) | int'(bn.timeout_err_out), 0);
    check_value({tag, " beat_err"}, int'(bw.beat_err_out) | int'(bn.beat_err_out), 0);
    check_forces(tag);
  endtask

  task automatic set_plan(input int g, input int n, input int md, input int fx, input int fy);
    nb[g] = n;
    mode[g] = md;
    for (int k = 0; k < MAXB; k++) begin
      px[g][k] = fx;
      py[g][k] = fy;
    end
  endtask

  task automatic random_plan();
    gmax = $urandom_range(0, 2);
    for (int g = 0; g < NG; g++) begin
      mode[g] = ($urandom_range(0, 9) < 2) ? 2 : $urandom_range(0, 1);
      nb[g]   = $urandom_range((mode[g] == 0) ? 1 : 0, MAXB);
      for (int k = 0; k < MAXB; k++) begin
        px[g][k] = $urandom_range(0, 255) - 128;
        py[g][k] = $urandom_range(0, 255) - 128;
      end
    end
  endtask

  task automatic run_step();
    int pulses;
    for (int n = 0; n < NN; n++) begin
      mxw[n] = 0; myw[n] = 0; mxn[n] = 0; myn[n] = 0;
    end
    exp_to = 0;
    exp_be = 0;
    @(negedge clk);
    step_noise = 1'b0;
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    step = 1'b1;
    @(negedge clk);
    check_value("busy_on_accept", int'(bw.busy_out), 1);
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    for (int g = 0; g < NG; g++) begin
      check_value($sformatf("begin gen%0d", g), int'(bw.gen_begin_out), 1 << g);
      check_value($sformatf("begin8 gen%0d", g), int'(bn.gen_begin_out), 1 << g);
      step_noise = 1'b1;
      drive_cycle(-1, 1'b0, 1'b0, 0, 0);
      cyc = 0;
      beat_cnt = 0;
      for (int k = 0; k < nb[g]; k++) begin
        repeat ($urandom_range(0, gmax)) collect_cycle(g, 1'b0, 1'b0, 0, 0);
        collect_cycle(g, 1'b1, (mode[g] == 0) && (k == nb[g] - 1), px[g][k], py[g][k]);
        model_beat(g, k);
      end
      if (mode[g] == 1) collect_cycle(g, 1'b0, 1'b1, 0, 0);
      if (mode[g] == 2) begin
        while (cyc < TO) collect_cycle(g, 1'b0, 1'b0, 0, 0);
        exp_to = 1;
      end
      @(negedge clk);
    end
    step_noise = 1'b0;
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    check_value("step_done", int'(bw.step_done_out), 1);
    check_value("step_done8", int'(bn.step_done_out), 1);
    check_value("busy_in_done", int'(bw.busy_out), 1);
    check_value("timeout_err", int'(bw.timeout_err_out), exp_to);
    check_value("timeout_err8", int'(bn.timeout_err_out), exp_to);
    check_value("beat_err", int'(bw.beat_err_out), exp_be);
    check_value("beat_err8", int'(bn.beat_err_out), exp_be);
    check_forces("done");
    @(negedge clk);
    check_value("step_done_width", int'(bw.step_done_out), 0);
    check_value("busy_after", int'(bw.busy_out), 0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      drive_cycle(-1, 1'b0, 1'b0, 0, 0);
      pulses += int'(bw.step_done_out) + int'(bw.busy_out);
    end
    check_value("no_extra_step", pulses, 0);
    check_forces("held");
  endtask

  task automatic reset_abort();
    int seen;
    @(negedge clk);
    step_noise = 1'b0;
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    step = 1'b1;
    @(negedge clk);
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      drive_cycle(0, 1'b1, 1'b0, 7, -5);
    end
    @(negedge clk);
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(-1, 1'b0, 1'b0, 0, 0);
    check_all_zero("abort");
    seen = 0;
    repeat (TO + 20) begin
      @(negedge clk);
      drive_cycle(-1, 1'b0, 1'b0, 0, 0);
      seen += int'(bw.step_done_out) + int'(bw.busy_out) + int'(bw.gen_begin_out);
    end
    check_value("abort_quiet", seen, 0);
  endtask

  initial begin
    for (int h = 0; h < NG; h++) begin
      gfx[h] = '0;
      gfy[h] = '0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    gmax = 0;
    set_plan(0, 10, 0, 2, -1);
    set_plan(1, 10, 0, 3, 4);
    set_plan(2, 10, 0, -1, 0);
    run_step();

    gmax = 1;
    set_plan(0, 10, 0, 100, -100);
    set_plan(1, 10, 1, 100, -100);
    set_plan(2, 10, 0, 100, -100);
    run_step();

    gmax = 0;
    set_plan(0, 10, 0, 5, -3);
    set_plan(1, 6, 2, 9, 9);
    set_plan(2, 10, 0, -2, 1);
    run_step();

    set_plan(0, 12, 1, 4, 6);
    set_plan(1, 4, 0, 1, -1);
    set_plan(2, 10, 0, -3, 2);
    run_step();

    reset_abort();

    for (int s = 0; s < 25; s++) begin
      random_plan();
      run_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/force_step_sequencer.md
Name: force_step_sequencer

Overview:
- Per-physics-step controller that shares one per-node force accumulator among NUM_GENS force generators: torque, spring, gravity, and others.
- On each step it launches the generators one at a time with a begin pulse, then sums each generator's per-node force stream into saturating X/Y accumulators.
- When all generators have finished, it presents the summed force arrays to the integrator and signals step completion.
- Includes a per-generator watchdog so that a hung generator cannot stall the simulation.

Parameters:
- NUM_NODES, 10: nodes per body; also the beats expected per generator stream.
- NUM_GENS, 3: number of force generators sequenced, in index order 0..NUM_GENS-1.
- FORCE_SIZE, 8: width of signed generator force inputs.
- ACC_SIZE, 12: width of signed accumulators and force outputs; must be ≥ FORCE_SIZE.
- TIMEOUT, 64: maximum cycles spent in COLLECT for one generator before it is abandoned.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- step_in  input  1  one-cycle request to start a physics step.
- gen_begin_out  output  [NUM_GENS]  one-cycle begin pulse to the selected generator.
- gen_force_x_in  input  signed [FORCE_SIZE] x [NUM_GENS]  X force beat from each generator.
- gen_force_y_in  input  signed [FORCE_SIZE] x [NUM_GENS]  Y force beat from each generator.
- gen_valid_in  input  [NUM_GENS]  force beat valid, one per generator.
- gen_done_in  input  [NUM_GENS]  generator-finished pulse, one per generator.
- force_x_out  output  signed [ACC_SIZE] x [NUM_NODES]  summed X force per node.
- force_y_out  output  signed [ACC_SIZE] x [NUM_NODES]  summed Y force per node.
- busy_out  output  1  high from step acceptance until step_done_out.
- step_done_out  output  1  one-cycle pulse; force outputs are final.
- timeout_err_out  output  1  sticky per step: some generator timed out.
- beat_err_out  output  1  sticky per step: some generator sent a beat beyond NUM_NODES.

Behaviour:
- Reset values: all outputs are 0, all accumulators are 0, state is IDLE, and the generator index, beat counter and watchdog are 0.
- Reset applied mid-step aborts the step immediately. No step_done_out is produced for the aborted step.
- States: IDLE, CLEAR, LAUNCH, COLLECT, DONE.
- IDLE:
  - busy_out = 0.
  - step_in = 1 moves to CLEAR and sets busy_out = 1 on the same edge.
  - step_in while busy_out = 1 is ignored; it is neither queued nor counted.
- CLEAR (one cycle):
  - Zeroes all accumulators, timeout_err_out and beat_err_out.
  - Sets generator index g = 0 and moves to LAUNCH.
- LAUNCH (one cycle):
  - gen_begin_out[g] = 1 for exactly this cycle; all other bits are 0.
  - Beat counter and watchdog are set to 0; next state is COLLECT.
  - gen_begin_out[0] is therefore high in the 2nd cycle after the edge that samples step_in.
- COLLECT:
  - Only generator g's inputs are observed; the valid, done and force inputs of every other generator are ignored.
  - When gen_valid_in[g] is high and beat < NUM_NODES:
    - acc_x[beat] += sign-extended gen_force_x_in[g], and acc_y[beat] likewise with gen_force_y_in[g].
    - Each sum saturates to the range -2^(ACC_SIZE-1) .. 2^(ACC_SIZE-1)-1.
    - beat increments.
  - When gen_valid_in[g] is high and beat == NUM_NODES, the beat is discarded and beat_err_out is set.
  - When gen_done_in[g] is high:
    - If valid is also high in the same cycle, that beat is accumulated first.
    - If g == NUM_GENS-1, go to DONE; otherwise g increments and the state returns to LAUNCH.
    - A generator may finish with fewer than NUM_NODES beats; untouched nodes keep their sums and no error is flagged.
  - The watchdog counts every COLLECT cycle. On reaching TIMEOUT-1 with no done:
    - timeout_err_out is set.
    - The state advances exactly as if done had arrived; a valid beat in that cycle is still accumulated.
- DONE (one cycle):
  - step_done_out = 1 and busy_out drops to 0 on the exit edge; next state is IDLE.
- Output holding:
  - force_x_out and force_y_out are driven continuously from the accumulators.
  - They hold their values through IDLE until the next CLEAR.
  - Their values are only guaranteed final while step_done_out is high or busy_out is low.
- Error flag lifetime: both error flags hold until the next CLEAR or reset.
- Minimum step length with NUM_GENS generators that each stream NUM_NODES back-to-back beats followed by a done pulse is 1 + NUM_GENS*(2+NUM_NODES) + 1 cycles, measured from the step_in edge to step_done_out.

Test Plan:
- Single step, ordinary streams:
  - Stimulus: NUM_GENS=3, NUM_NODES=10; gen0 sends x=+2/y=-1 per node, gen1 sends x=+3/y=+4, gen2 sends x=-1/y=0; each generator pulses done after 10 beats.
  - Required: every node reads x=+4, y=+3; step_done_out is a single 1-cycle pulse; both error flags stay 0.
- Begin sequencing:
  - Required: gen_begin_out shows 3'b001, then 3'b010, then 3'b100, each 1 cycle wide, each following the previous generator's done.
  - Required: a spurious gen_valid_in[2] during gen0's slot changes no accumulator.
- Saturation:
  - Stimulus: ACC_SIZE=8, FORCE_SIZE=8; three generators each send x=+100 to node 0.
  - Required: force_x_out[0] = +127, not a wrapped value; repeating with -100 gives -128.
- Hung generator:
  - Stimulus: gen1 never pulses done.
  - Required: after TIMEOUT=64 COLLECT cycles the block launches gen2; timeout_err_out = 1; the step completes; gen0 and gen2 sums are still present.
- Beat overflow, early done, and valid+done together:
  - gen0 sends 12 beats: nodes 0-9 are accumulated, the extras are dropped, beat_err_out = 1.
  - gen1 sends 4 beats then done: nodes 4-9 hold gen0's values only, with no error from this.
  - A beat arriving with valid and done high together is counted.
- Busy and reset behaviour:
  - step_in pulsed during COLLECT is ignored, giving exactly one step_done_out.
  - rst_in asserted mid-COLLECT gives all outputs 0 on the next cycle, no step_done_out, and the next step_in runs normally.
